// File: rtl/game_state_controller.sv
// game_state_controller
//   Round sequencer for a two-player fighting game. A start press leaves
//   IDLE and opens the READY -> SET -> FIGHT banner sequence. The banners are
//   timed in frame ticks and lead into FIGHTING. A knockout there leads to a
//   timed winner screen, and the winner's round score goes up by one. Scores
//   saturate at 9 and only rst clears them.
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous, active-high reset
//   start_btn      synchronised, debounced start button level
//   tick           one-cycle frame timebase strobe
//   p1_dead        level, player 1 health is zero
//   p2_dead        level, player 2 health is zero
//   game_state     0 IDLE, 1 READY, 2 SET, 3 FIGHT, 4 FIGHTING, 5 P1_WIN, 6 P2_WIN
//                  (this is the FSM state register itself)
//   fight_active   registered, high only while game_state == FIGHTING
//   state_changed  registered, one-cycle pulse in the first cycle of a new state
//   p1_score       round wins for player 1, 0..9
//   p2_score       round wins for player 2, 0..9
//
// There is no valid/ready handshake here. start_btn is edge-detected
// internally. tick and the dead flags are sampled as plain levels on each
// rising edge.
module game_state_controller #(
    parameter logic [7:0] READY_TICKS = 8'd60,
    parameter logic [7:0] SET_TICKS   = 8'd60,
    parameter logic [7:0] FIGHT_TICKS = 8'd60,
    parameter logic [7:0] WIN_TICKS   = 8'd180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       tick,
    input  logic       p1_dead,
    input  logic       p2_dead,
    output logic [2:0] game_state,
    output logic       fight_active,
    output logic       state_changed,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READY    = 3'd1,
        S_SET      = 3'd2,
        S_FIGHT    = 3'd3,
        S_FIGHTING = 3'd4,
        S_P1_WIN   = 3'd5,
        S_P2_WIN   = 3'd6
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [3:0] p1_nxt, p2_nxt;
    logic       btn_q;
    logic       press;

    // btn_q resets to 1, so a button held through reset does not count as a
    // press. The player must release it and press again.
    assign press      = start_btn & ~btn_q;
    assign game_state = state;

    // A zero duration would underflow the counter, so it is treated as one tick.
    function automatic logic [7:0] nz(input logic [7:0] p);
        return (p == 8'd0) ? 8'd1 : p;
    endfunction

    function automatic logic [7:0] load_of(input state_t s);
        case (s)
            S_READY:            return nz(READY_TICKS);
            S_SET:              return nz(SET_TICKS);
            S_FIGHT:            return nz(FIGHT_TICKS);
            S_P1_WIN, S_P2_WIN: return nz(WIN_TICKS);
            default:            return 8'd0;
        endcase
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= 4'd9) ? 4'd9 : v + 4'd1;
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        p1_nxt    = p1_score;
        p2_nxt    = p2_score;
        case (state)
            S_IDLE: begin
                if (press) state_nxt = S_READY;
            end
            S_READY, S_SET, S_FIGHT, S_P1_WIN, S_P2_WIN: begin
                // A press on a winner screen beats a coincident tick.
                if ((state == S_P1_WIN || state == S_P2_WIN) && press) begin
                    state_nxt = S_IDLE;
                end else if (tick) begin
                    // The tick that finds the counter at 1 is the last tick of
                    // this state, so a state loaded with N lasts exactly N ticks.
                    if (cnt <= 8'd1) begin
                        case (state)
                            S_READY: state_nxt = S_SET;
                            S_SET:   state_nxt = S_FIGHT;
                            S_FIGHT: state_nxt = S_FIGHTING;
                            default: state_nxt = S_IDLE;
                        endcase
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
            end
            S_FIGHTING: begin
                if (p2_dead && !p1_dead) begin
                    state_nxt = S_P1_WIN;
                    p1_nxt    = sat_inc(p1_score);
                end else if (p1_dead && !p2_dead) begin
                    state_nxt = S_P2_WIN;
                    p2_nxt    = sat_inc(p2_score);
                end else if (p1_dead && p2_dead) begin
                    // A double knockout is a draw. No score changes.
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Every state entry reloads the counter. Untimed states load 0.
        if (state_nxt != state) cnt_nxt = load_of(state_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= 8'd0;
            fight_active  <= 1'b0;
            state_changed <= 1'b0;
            p1_score      <= 4'd0;
            p2_score      <= 4'd0;
            btn_q         <= 1'b1;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            fight_active  <= (state_nxt == S_FIGHTING);
            state_changed <= (state_nxt != state);
            p1_score      <= p1_nxt;
            p2_score      <= p2_nxt;
            btn_q         <= start_btn;
        end
    end

endmodule

// File: tb/tb_game_state_controller.sv
// tb_game_state_controller
//   Bench for game_state_controller. The banner durations are 2 ticks each
//   and the winner screens last 3 ticks. Stimulus is applied on the falling
//   edge, and each applied cycle queues its expected outputs. A monitor pops
//   one entry one time unit after every rising edge that has an entry queued,
//   and compares it with the outputs.
module tb_game_state_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_btn = 1'b0;
    logic       tick = 1'b0;
    logic       p1_dead = 1'b0;
    logic       p2_dead = 1'b0;
    logic [2:0] game_state;
    logic       fight_active, state_changed;
    logic [3:0] p1_score, p2_score;

    int checks   = 0;
    int failures = 0;

    // expected = {game_state, fight_active, state_changed, p1_score, p2_score}
    logic [12:0] exp_q[$];
    string       tag_q[$];

    logic [3:0]  e_p1 = 4'd0;
    logic [3:0]  e_p2 = 4'd0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    game_state_controller #(
        .READY_TICKS(8'd2),
        .SET_TICKS  (8'd2),
        .FIGHT_TICKS(8'd2),
        .WIN_TICKS  (8'd3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_btn    (start_btn),
        .tick         (tick),
        .p1_dead      (p1_dead),
        .p2_dead      (p2_dead),
        .game_state   (game_state),
        .fight_active (fight_active),
        .state_changed(state_changed),
        .p1_score     (p1_score),
        .p2_score     (p2_score)
    );

    // ---------------- driver ----------------
    // Applies one cycle of inputs and queues the outputs expected after the
    // next rising edge. The expected scores are taken from e_p1 and e_p2.
    task automatic step(input logic r, input logic s, input logic t,
                        input logic d1, input logic d2,
                        input logic [2:0] est, input logic esc, input string tag);
        @(negedge clk);
        rst = r; start_btn = s; tick = t; p1_dead = d1; p2_dead = d2;
        exp_q.push_back({est, (est == 3'd4), esc, e_p1, e_p2});
        tag_q.push_back(tag);
    endtask

    // Starts from IDLE with the button released. A press enters READY, and
    // then READY, SET and FIGHT each last 2 ticks before FIGHTING begins.
    task automatic to_fighting(input string tag);
        step(0, 1, 0, 0, 0, 3'd1, 1'b1, {tag, "_press"});
        for (int s = 1; s <= 3; s++) begin
            step(0, 0, 1, 0, 0, 3'(s),     1'b0, {tag, "_tick_a"});
            step(0, 0, 1, 0, 0, 3'(s + 1), 1'b1, {tag, "_tick_b"});
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        logic [12:0] e;
        logic [12:0] a;
        string       t;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {game_state, fight_active, state_changed, p1_score, p2_score};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got st=%0d fa=%0b sc=%0b p1=%0d p2=%0d, expected st=%0d fa=%0b sc=%0b p1=%0d p2=%0d",
                         t, a[12:10], a[9], a[8], a[7:4], a[3:0],
                         e[12:10], e[9], e[8], e[7:4], e[3:0]);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic       r, s, t, d1, d2;
        logic [2:0] st;
        logic       sc;
        logic [3:0] p1, p2;
    } vec_t;

    vec_t vecs[16];

    initial begin
        //          r  s  t d1 d2  st sc p1 p2
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};  // reset
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};  // idle, button low
        vecs[2]  = '{0, 1, 0, 0, 0, 1, 1, 0, 0};  // press -> READY
        vecs[3]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0};  // tick 1 of READY
        vecs[4]  = '{0, 0, 1, 0, 0, 2, 1, 0, 0};  // tick 2 -> SET
        vecs[5]  = '{0, 0, 0, 0, 0, 2, 0, 0, 0};  // no tick
        vecs[6]  = '{0, 0, 1, 0, 0, 2, 0, 0, 0};
        vecs[7]  = '{0, 0, 1, 0, 0, 3, 1, 0, 0};  // -> FIGHT
        vecs[8]  = '{0, 1, 0, 0, 0, 3, 0, 0, 0};  // press ignored in FIGHT
        vecs[9]  = '{0, 0, 1, 0, 0, 3, 0, 0, 0};
        vecs[10] = '{0, 0, 1, 0, 0, 4, 1, 0, 0};  // -> FIGHTING
        vecs[11] = '{0, 0, 0, 0, 1, 5, 1, 1, 0};  // p2 dead -> P1_WIN
        vecs[12] = '{0, 0, 1, 0, 1, 5, 0, 1, 0};  // dead ignored, win tick 1
        vecs[13] = '{0, 0, 1, 0, 0, 5, 0, 1, 0};  // win tick 2
        vecs[14] = '{0, 0, 1, 0, 0, 0, 1, 1, 0};  // win tick 3 -> IDLE
        vecs[15] = '{0, 0, 0, 1, 1, 0, 0, 1, 0};  // dead ignored in IDLE

        repeat (2) @(posedge clk);

        for (int i = 0; i < 16; i++) begin
            e_p1 = vecs[i].p1;
            e_p2 = vecs[i].p2;
            step(vecs[i].r, vecs[i].s, vecs[i].t, vecs[i].d1, vecs[i].d2,
                 vecs[i].st, vecs[i].sc, $sformatf("vec%0d", i));
        end

        // Draw: both players die in the same cycle. IDLE, scores unchanged.
        to_fighting("draw");
        step(0, 0, 0, 1, 1, 3'd0, 1'b1, "draw_idle");
        step(0, 0, 0, 0, 0, 3'd0, 1'b0, "draw_hold");

        // Ten P2 wins. The score saturates at 9. Each winner screen ends with
        // a press that coincides with the counter's final tick.
        for (int w = 1; w <= 10; w++) begin
            to_fighting("p2win");
            e_p2 = (e_p2 < 4'd9) ? e_p2 + 4'd1 : 4'd9;
            step(0, 0, 0, 1, 0, 3'd6, 1'b1, $sformatf("p2win%0d_enter", w));
            step(0, 0, 1, 0, 0, 3'd6, 1'b0, "p2win_tick1");
            step(0, 0, 1, 0, 0, 3'd6, 1'b0, "p2win_tick2");
            step(0, 1, 1, 0, 0, 3'd0, 1'b1, "p2win_press_tick");
            step(0, 0, 0, 0, 0, 3'd0, 1'b0, "p2win_idle");
        end

        // Two more P1 wins bring p1_score to 3. A press leaves early each time.
        for (int w = 0; w < 2; w++) begin
            to_fighting("p1win");
            e_p1 = e_p1 + 4'd1;
            step(0, 0, 0, 0, 1, 3'd5, 1'b1, "p1win_enter");
            step(0, 1, 0, 0, 0, 3'd0, 1'b1, "p1win_press");
            step(0, 0, 0, 0, 0, 3'd0, 1'b0, "p1win_idle");
        end

        // A reset during SET aborts the round and clears both scores.
        step(0, 1, 0, 0, 0, 3'd1, 1'b1, "rst_set_press");
        step(0, 0, 1, 0, 0, 3'd1, 1'b0, "rst_set_t1");
        step(0, 0, 1, 0, 0, 3'd2, 1'b1, "rst_set_t2");
        e_p1 = 4'd0;
        e_p2 = 4'd0;
        step(1, 0, 0, 0, 0, 3'd0, 1'b0, "rst_in_set");
        step(0, 0, 0, 0, 0, 3'd0, 1'b0, "rst_release");

        // A press during FIGHTING is ignored. A reset during FIGHTING, with a
        // coincident knockout, gives no score.
        to_fighting("fpress");
        step(0, 1, 0, 0, 0, 3'd4, 1'b0, "fighting_press");
        step(0, 0, 0, 0, 0, 3'd4, 1'b0, "fighting_hold");
        step(1, 0, 0, 0, 1, 3'd0, 1'b0, "rst_in_fighting");

        // A button held through reset release is not a press.
        step(1, 1, 0, 0, 0, 3'd0, 1'b0, "held_rst");
        step(0, 1, 0, 0, 0, 3'd0, 1'b0, "held_release");
        step(0, 0, 0, 0, 0, 3'd0, 1'b0, "held_let_go");
        step(0, 1, 0, 0, 0, 3'd1, 1'b1, "held_repress");
        step(0, 0, 0, 0, 0, 3'd1, 1'b0, "held_ready");

        @(negedge clk);
        rst = 1'b0; start_btn = 1'b0; tick = 1'b0; p1_dead = 1'b0; p2_dead = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_state_controller.md
GAME_STATE_CONTROLLER -- requirements
Module: game_state_controller

Interface
REQ-001 Parameter READY_TICKS, default 8'd60, duration of READY in ticks.
REQ-002 Parameter SET_TICKS, default 8'd60, duration of SET in ticks.
REQ-003 Parameter FIGHT_TICKS, default 8'd60, duration of FIGHT banner in ticks.
REQ-004 Parameter WIN_TICKS, default 8'd180, duration of each winner state in ticks.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start_btn  input  1  synchronised, debounced start button level.
REQ-008 tick  input  1  one-cycle timebase strobe (frame rate).
REQ-009 p1_dead  input  1  level, player 1 health reached zero.
REQ-010 p2_dead  input  1  level, player 2 health reached zero.
REQ-011 game_state  output  3  0 IDLE, 1 READY, 2 SET, 3 FIGHT, 4 FIGHTING, 5 P1_WIN, 6 P2_WIN.
REQ-012 fight_active  output  1  high only while game_state==4.
REQ-013 state_changed  output  1  one-cycle pulse in the first cycle of any new game_state value.
REQ-014 p1_score, p2_score  output  4 each  round wins per player.

Function
REQ-015 Rising-edge detect on start_btn via one registered copy; "press" means start_btn=1 while the previous sample was 0.
REQ-016 IDLE -> READY on press; all other inputs are ignored in IDLE.
REQ-017 On entry to each timed state (1, 2, 3, 5, 6), an 8-bit down-counter loads that state's parameter; a parameter of 0 is loaded as 1.
REQ-018 The counter decrements only on tick; a tick with counter==1 advances the state on that edge, so each timed state lasts exactly N ticks.
REQ-019 Timed transitions: READY -> SET -> FIGHT -> FIGHTING; P1_WIN/P2_WIN -> IDLE.
REQ-020 Press is ignored in READY, SET, FIGHT and FIGHTING.
REQ-021 A press in P1_WIN/P2_WIN returns to IDLE immediately, abandoning the counter.
REQ-022 FIGHTING with p2_dead=1 and p1_dead=0 -> P1_WIN; p1_score increments on that same edge.
REQ-023 FIGHTING with p1_dead=1 and p2_dead=0 -> P2_WIN; p2_score increments on that same edge.
REQ-024 FIGHTING with both dead in the same cycle (draw) -> IDLE; no score change.
REQ-025 p1_dead/p2_dead are ignored outside FIGHTING.
REQ-026 Scores saturate at 4'd9; further wins hold 9.
REQ-027 Scores persist across rounds; only rst clears them.
REQ-028 game_state, fight_active and state_changed are registered outputs; game_state never takes value 7.
REQ-029 tick coincident with a press in a winner state: the press takes priority.

Reset
REQ-030 While rst=1 at a clock edge: game_state=0, counter=0, fight_active=0, state_changed=0, scores=0, edge-detect register=1.
REQ-031 Edge-detect reset value 1 ensures a button held through reset does not generate a press.
REQ-032 rst asserted mid-round (any state) aborts the round on that edge with no score update.

Verification
REQ-033 Reset, pulse start_btn, READY/SET/FIGHT_TICKS=2, tick every 4 cycles -> states 1,2,3 each last exactly 2 ticks, then 4 with fight_active=1, one state_changed pulse per transition.
REQ-034 In FIGHTING, assert p2_dead -> next edge game_state=5, p1_score=1; after WIN_TICKS ticks -> 0.
REQ-035 In FIGHTING, assert p1_dead and p2_dead in the same cycle -> game_state=0, both scores unchanged.
REQ-036 Ten consecutive P2 wins -> p2_score sequence 1..9, then holds 9.
REQ-037 Hold start_btn=1 through rst release -> stays IDLE; release and press -> READY.
REQ-038 rst pulse during SET with p1_score=3 -> game_state=0, p1_score=0; start during FIGHTING -> no change.
